// File: rtl/sdram_host_port_if.sv
// Bus bundle between the CPU-side sequencer and the SDRAM FIFO front end.
// The slave modport is the sequencer's view; master is the environment's view.
interface sdram_host_port_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic [15:0] cpu_rdata;
    logic        cpu_err;
    logic        err_sticky;
    logic        err_clr;
    logic [23:0] ram_addr;
    logic [15:0] ram_wr_data;
    logic        ram_wr_en;
    logic        ram_rd_en;
    logic        ram_busy;
    logic        ram_rd_ready;
    logic [15:0] ram_rd_data;
    logic        ram_rd_pop;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, err_clr,
               ram_busy, ram_rd_ready, ram_rd_data,
        output cpu_ready, cpu_done, cpu_rdata, cpu_err, err_sticky,
               ram_addr, ram_wr_data, ram_wr_en, ram_rd_en, ram_rd_pop
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, err_clr,
               ram_busy, ram_rd_ready, ram_rd_data,
        input  cpu_ready, cpu_done, cpu_rdata, cpu_err, err_sticky,
               ram_addr, ram_wr_data, ram_wr_en, ram_rd_en, ram_rd_pop
    );
endinterface

// File: rtl/sdram_host_port.sv
// CPU load/store sequencer feeding the SDRAM request/response FIFOs, with
// per-access timeout and draining of read data that arrives after a timeout.
module sdram_host_port #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STALE_MAX      = 7
) (
    input  logic               clk,
    input  logic               rst,
    sdram_host_port_if.slave   bus
);

    localparam int SW = $clog2(STALE_MAX + 1);
    localparam logic [SW-1:0] STALE_TOP = SW'(STALE_MAX);
    localparam logic [SW-1:0] STALE_ONE = SW'(1);
    localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_RD      = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_RSP     = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [15:0]   to_cnt_q, to_cnt_d;
    logic [SW-1:0] stale_cnt_q, stale_cnt_d;
    logic [23:0]   ram_addr_q, ram_addr_d;
    logic [15:0]   ram_wr_data_q, ram_wr_data_d;
    logic [15:0]   cpu_rdata_q, cpu_rdata_d;
    logic          err_sticky_q, err_sticky_d;

    logic in_access;
    logic timeout;
    logic ready;
    logic wr_en, rd_en, pop, done, err, force_ones;

    assign in_access = (state_q == ST_WR) || (state_q == ST_RD) || (state_q == ST_RD_WAIT);
    assign timeout   = in_access && (to_cnt_q == TO_LAST);
    assign ready     = (state_q == ST_IDLE) && (stale_cnt_q < STALE_TOP);

    always_comb begin
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        stale_cnt_d   = stale_cnt_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        cpu_rdata_d   = cpu_rdata_q;
        err_sticky_d  = err_sticky_q;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        pop           = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        force_ones    = 1'b0;

        if (in_access) to_cnt_d = to_cnt_q + 16'd1;
        if (bus.err_clr) err_sticky_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ready && bus.cpu_req) begin
                    ram_addr_d    = bus.cpu_addr;
                    ram_wr_data_d = bus.cpu_wdata;
                    to_cnt_d      = 16'd0;
                    state_d       = bus.cpu_we ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                if (!timeout && !bus.ram_busy) begin
                    wr_en   = 1'b1;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (!timeout && !bus.ram_busy) begin
                    rd_en   = 1'b1;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                // Older stale words sit ahead of our own data in the FIFO.
                if (!timeout && bus.ram_rd_ready) begin
                    pop = 1'b1;
                    if (stale_cnt_q != '0) begin
                        stale_cnt_d = stale_cnt_q - STALE_ONE;
                    end else begin
                        cpu_rdata_d = bus.ram_rd_data;
                        state_d     = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (!timeout && state_q != ST_RD_WAIT && bus.ram_rd_ready && stale_cnt_q != '0) begin
            pop         = 1'b1;
            stale_cnt_d = stale_cnt_q - STALE_ONE;
        end

        // Timeout overrides everything: no FIFO strobes, error completion, and a
        // read abandoned after issue leaves one late word to be discarded.
        if (timeout) begin
            done         = 1'b1;
            err          = 1'b1;
            err_sticky_d = 1'b1;
            state_d      = ST_IDLE;
            if (state_q != ST_WR) begin
                force_ones  = 1'b1;
                cpu_rdata_d = 16'hFFFF;
            end
            if (state_q == ST_RD_WAIT && stale_cnt_q != STALE_TOP) begin
                stale_cnt_d = stale_cnt_q + STALE_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            to_cnt_q      <= 16'd0;
            stale_cnt_q   <= '0;
            ram_addr_q    <= 24'd0;
            ram_wr_data_q <= 16'd0;
            cpu_rdata_q   <= 16'd0;
            err_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            stale_cnt_q   <= stale_cnt_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            cpu_rdata_q   <= cpu_rdata_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    assign bus.cpu_ready   = !rst && ready;
    assign bus.cpu_done    = !rst && done;
    assign bus.cpu_err     = !rst && err;
    assign bus.ram_wr_en   = !rst && wr_en;
    assign bus.ram_rd_en   = !rst && rd_en;
    assign bus.ram_rd_pop  = !rst && pop;
    assign bus.cpu_rdata   = (force_ones && !rst) ? 16'hFFFF : cpu_rdata_q;
    assign bus.err_sticky  = err_sticky_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wr_data = ram_wr_data_q;

endmodule

// File: tb/tb_sdram_host_port.sv
// Directed bench for sdram_host_port with a short timeout so that timeout,
// stale-drain and saturation paths are reachable in a few hundred cycles.
module tb_sdram_host_port;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    sdram_host_port_if bus ();

    sdram_host_port #(
        .TIMEOUT_CYCLES(16),
        .STALE_MAX     (7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and land just after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic we,
                                 input logic [23:0] addr, input logic [15:0] wdata);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b0, 1'b0, 24'd0, 16'd0);
        bus.err_clr      = 1'b0;
        bus.ram_busy     = 1'b0;
        bus.ram_rd_ready = 1'b0;
        bus.ram_rd_data  = 16'd0;

        // Reset behaviour
        cyc(2); #2;
        checkOutput("rst_ready", 32'(bus.cpu_ready), 32'd0);
        checkOutput("rst_done", 32'(bus.cpu_done), 32'd0);
        checkOutput("rst_strobes", 32'({bus.ram_wr_en, bus.ram_rd_en, bus.ram_rd_pop}), 32'd0);
        cyc(1);
        rst = 1'b0;
        #2;
        checkOutput("rst_addr", 32'(bus.ram_addr), 32'd0);
        checkOutput("rst_wdata", 32'(bus.ram_wr_data), 32'd0);
        checkOutput("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
        checkOutput("rst_sticky", 32'(bus.err_sticky), 32'd0);
        checkOutput("idle_ready", 32'(bus.cpu_ready), 32'd1);

        // Write with no back-pressure
        $display("[TB] write, no back-pressure");
        applyStimulus(1'b1, 1'b1, 24'h000123, 16'hBEEF);
        cyc(1);
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
        #2;
        checkOutput("wr_en", 32'(bus.ram_wr_en), 32'd1);
        checkOutput("wr_addr", 32'(bus.ram_addr), 32'h000123);
        checkOutput("wr_data", 32'(bus.ram_wr_data), 32'hBEEF);
        checkOutput("wr_done", 32'({bus.cpu_done, bus.cpu_err}), 32'b10);
        checkOutput("wr_busy_ready", 32'(bus.cpu_ready), 32'd0);
        cyc(1); #2;
        checkOutput("wr_next_ready", 32'(bus.cpu_ready), 32'd1);
        checkOutput("wr_next_done", 32'({bus.cpu_done, bus.ram_wr_en}), 32'd0);

        // Write with 5 cycles of back-pressure
        $display("[TB] write with back-pressure");
        applyStimulus(1'b1, 1'b1, 24'h000456, 16'hCAFE);
        bus.ram_busy = 1'b1;
        cyc(1);
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            #2;
            checkOutput("bp_no_wr", 32'({bus.ram_wr_en, bus.cpu_done}), 32'd0);
            checkOutput("bp_addr", 32'(bus.ram_addr), 32'h000456);
            cyc(1);
        end
        bus.ram_busy = 1'b0;
        #2;
        checkOutput("bp_wr_en", 32'({bus.ram_wr_en, bus.cpu_done, bus.cpu_err}), 32'b110);
        checkOutput("bp_addr_last", 32'(bus.ram_addr), 32'h000456);
        checkOutput("bp_data_last", 32'(bus.ram_wr_data), 32'hCAFE);
        cyc(1);

        // Read with 6-cycle return latency
        $display("[TB] read");
        applyStimulus(1'b1, 1'b0, 24'h0000A0, 16'h0);
        cyc(1);
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
        #2;
        checkOutput("rd_en", 32'(bus.ram_rd_en), 32'd1);
        checkOutput("rd_addr", 32'(bus.ram_addr), 32'h0000A0);
        for (int i = 0; i < 5; i++) begin
            cyc(1); #2;
            checkOutput("rd_wait_quiet", 32'({bus.ram_rd_pop, bus.cpu_done, bus.ram_rd_en}), 32'd0);
        end
        cyc(1);
        bus.ram_rd_ready = 1'b1;
        bus.ram_rd_data  = 16'h1234;
        #2;
        checkOutput("rd_pop", 32'({bus.ram_rd_pop, bus.cpu_done}), 32'b10);
        cyc(1);
        bus.ram_rd_ready = 1'b0;
        bus.ram_rd_data  = 16'h0;
        #2;
        checkOutput("rd_done", 32'({bus.cpu_done, bus.cpu_err, bus.ram_rd_pop}), 32'b100);
        checkOutput("rd_data", 32'(bus.cpu_rdata), 32'h1234);
        cyc(1); #2;
        checkOutput("rd_hold", 32'(bus.cpu_rdata), 32'h1234);
        checkOutput("rd_after_ready", 32'({bus.cpu_ready, bus.cpu_done}), 32'b10);

        // Read timeout, then late data drained while idle
        $display("[TB] read timeout");
        applyStimulus(1'b1, 1'b0, 24'h0000B0, 16'h0);
        cyc(1);
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
        #2;
        checkOutput("to_rd_en", 32'(bus.ram_rd_en), 32'd1);
        for (int i = 2; i < 16; i++) begin
            cyc(1); #2;
            checkOutput("to_no_early_done", 32'(bus.cpu_done), 32'd0);
        end
        cyc(1); #2;
        checkOutput("to_done_err", 32'({bus.cpu_done, bus.cpu_err}), 32'b11);
        checkOutput("to_rdata", 32'(bus.cpu_rdata), 32'hFFFF);
        checkOutput("to_no_strobe", 32'({bus.ram_wr_en, bus.ram_rd_en, bus.ram_rd_pop}), 32'd0);
        cyc(1);
        bus.ram_rd_ready = 1'b1;
        bus.ram_rd_data  = 16'hAAAA;
        #2;
        checkOutput("to_sticky", 32'(bus.err_sticky), 32'd1);
        checkOutput("to_rdata_hold", 32'(bus.cpu_rdata), 32'hFFFF);
        checkOutput("late_pop", 32'({bus.ram_rd_pop, bus.cpu_done}), 32'b10);
        cyc(1);
        bus.ram_rd_data = 16'h7777;
        #2;
        checkOutput("no_pop_after_drain", 32'(bus.ram_rd_pop), 32'd0);
        cyc(1);
        bus.ram_rd_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 24'h0000C0, 16'h0);
        cyc(1);
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
        #2;
        checkOutput("rd2_en", 32'(bus.ram_rd_en), 32'd1);
        cyc(1);
        bus.ram_rd_ready = 1'b1;
        bus.ram_rd_data  = 16'h5555;
        #2;
        checkOutput("rd2_pop", 32'(bus.ram_rd_pop), 32'd1);
        cyc(1);
        bus.ram_rd_ready = 1'b0;
        #2;
        checkOutput("rd2_done", 32'({bus.cpu_done, bus.cpu_err}), 32'b10);
        checkOutput("rd2_data", 32'(bus.cpu_rdata), 32'h5555);
        cyc(1);

        // err_clr alone
        bus.err_clr = 1'b1;
        cyc(1);
        bus.err_clr = 1'b0;
        #2;
        checkOutput("clr_sticky", 32'(bus.err_sticky), 32'd0);

        // Write timeout coincident with err_clr: set wins, rdata untouched
        $display("[TB] write timeout with err_clr");
        bus.ram_busy = 1'b1;
        applyStimulus(1'b1, 1'b1, 24'h000777, 16'h1111);
        cyc(1);
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
        cyc(15);
        bus.err_clr = 1'b1;
        #2;
        checkOutput("wto_done_err", 32'({bus.cpu_done, bus.cpu_err, bus.ram_wr_en}), 32'b110);
        checkOutput("wto_rdata", 32'(bus.cpu_rdata), 32'h5555);
        cyc(1);
        bus.err_clr  = 1'b0;
        bus.ram_busy = 1'b0;
        #2;
        checkOutput("wto_sticky", 32'(bus.err_sticky), 32'd1);
        checkOutput("wto_ready", 32'(bus.cpu_ready), 32'd1);

        // Seven read timeouts saturate the stale counter
        $display("[TB] stale saturation");
        for (int k = 0; k < 7; k++) begin
            checkOutput("sat_ready_before", 32'(bus.cpu_ready), 32'd1);
            applyStimulus(1'b1, 1'b0, 24'(k), 16'h0);
            cyc(1);
            applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
            cyc(15); #2;
            checkOutput("sat_timeout", 32'({bus.cpu_done, bus.cpu_err}), 32'b11);
            cyc(1); #2;
        end
        checkOutput("sat_not_ready", 32'(bus.cpu_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 24'h0000D0, 16'h0);
        cyc(1);
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
        #2;
        checkOutput("sat_no_accept", 32'({bus.ram_rd_en, bus.cpu_ready}), 32'd0);
        bus.ram_rd_ready = 1'b1;
        #1;
        checkOutput("sat_drain_pop", 32'(bus.ram_rd_pop), 32'd1);
        cyc(1);
        bus.ram_rd_ready = 1'b0;
        #2;
        checkOutput("sat_ready_again", 32'(bus.cpu_ready), 32'd1);

        // Reset while waiting for read data
        $display("[TB] reset in RD_WAIT");
        applyStimulus(1'b1, 1'b0, 24'h0000E0, 16'h0);
        cyc(1);
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
        #2;
        checkOutput("rr_rd_en", 32'(bus.ram_rd_en), 32'd1);
        cyc(2);
        rst = 1'b1;
        #2;
        checkOutput("rr_during", 32'({bus.cpu_done, bus.cpu_ready}), 32'd0);
        cyc(1);
        rst = 1'b0;
        bus.ram_rd_ready = 1'b1;
        #2;
        checkOutput("rr_idle", 32'({bus.cpu_ready, bus.cpu_done}), 32'b10);
        checkOutput("rr_stale_clear", 32'(bus.ram_rd_pop), 32'd0);
        cyc(1); #2;
        checkOutput("rr_no_done", 32'({bus.cpu_done, bus.ram_rd_pop}), 32'd0);
        bus.ram_rd_ready = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_host_port.md
# sdram_host_port

Processor-side access sequencer placed directly upstream of `sdram_block`, in the 1 MHz `mclk` domain. It converts single-word CPU load/store requests into the SDRAM FIFO strobes: write push, read-address push, and read-data pop. It handles back-pressure from `ram_busy`, waits for returned read data, and enforces a per-access timeout. After a timeout it discards the late read data that arrives, so the read-data FIFO stays aligned with requests.

## Interface
- `TIMEOUT_CYCLES`, 1024: cycles an access may stay in WR, RD or RD_WAIT before it is aborted; range 2..65535.
- `STALE_MAX`, 7: saturation value of the stale-read counter.
- `clk` in 1: processor clock (`mclk`).
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `cpu_req` in 1: request valid; sampled only while `cpu_ready`=1.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 24: word address.
- `cpu_wdata` in 16: write data.
- `cpu_ready` out 1: block is idle and accepts a request this cycle.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_rdata` out 16: read result; valid while `cpu_done`=1 and held until the next completion.
- `cpu_err` out 1: qualifies `cpu_done`; 1 = this access timed out.
- `err_sticky` out 1: set by any timeout; cleared by `err_clr`.
- `err_clr` in 1: clears `err_sticky`. If a timeout occurs in the same cycle, the set wins.
- `ram_addr` out 24: to `sdram_block`.
- `ram_wr_data` out 16: to `sdram_block`.
- `ram_wr_en` out 1: write-FIFO push strobe.
- `ram_rd_en` out 1: read-address-FIFO push strobe.
- `ram_busy` in 1: either request FIFO is full.
- `ram_rd_ready` in 1: read-data FIFO is non-empty.
- `ram_rd_data` in 16: head of the read-data FIFO (show-ahead).
- `ram_rd_pop` out 1: read-data FIFO pop strobe.

## Operation
- States: IDLE, WR, RD, RD_WAIT, RSP.
- IDLE
  - `cpu_ready` = 1 when `stale_cnt` < STALE_MAX.
  - On `cpu_req`, the block registers `cpu_addr`/`cpu_wdata` into `ram_addr`/`ram_wr_data`, clears the timeout counter, and moves to WR if `cpu_we`=1, otherwise RD.
- WR
  - `ram_wr_en` = !`ram_busy` (combinational).
  - On issue: `cpu_done`=1 and `cpu_err`=0 in the same cycle, then go to IDLE.
- RD
  - `ram_rd_en` = !`ram_busy`.
  - On issue: go to RD_WAIT.
- RD_WAIT, when `ram_rd_ready`=1:
  - `ram_rd_pop`=1.
  - If `stale_cnt`>0: decrement `stale_cnt`, discard the data, stay in RD_WAIT.
  - Otherwise: capture `ram_rd_data` into `cpu_rdata` and go to RSP.
- RSP: `cpu_done`=1 and `cpu_err`=0 for one cycle, then go to IDLE.
- Timeout counter
  - Increments every cycle spent in WR, RD or RD_WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without completing, the block:
    - aborts the access;
    - pulses `cpu_done`=1 with `cpu_err`=1 and sets `cpu_rdata`=16'hFFFF (reads only; on a write `cpu_rdata` is unchanged);
    - sets `err_sticky`;
    - returns to IDLE.
  - A timeout in RD_WAIT increments `stale_cnt`, saturating at STALE_MAX. A timeout in WR or RD issues nothing to the FIFOs and leaves `stale_cnt` unchanged.
- Stale drain: in IDLE, WR, RD and RSP, any cycle with `ram_rd_ready`=1 and `stale_cnt`>0 gives `ram_rd_pop`=1 and decrements `stale_cnt`. With `stale_cnt`=0, `ram_rd_ready` outside RD_WAIT is ignored and causes no pop.
- At most one read is outstanding in addition to the stale reads.
- `ram_wr_en`, `ram_rd_en` and `ram_rd_pop` are never asserted in the same cycle as one another, except that a stale pop may coincide with `ram_wr_en` or `ram_rd_en`.

## Timing
- Reset: state IDLE; `stale_cnt`, timeout counter, `ram_addr`, `ram_wr_data`, `cpu_rdata` = 0; all strobes, `cpu_done`, `cpu_err` and `err_sticky` = 0; `cpu_ready` = 0 while `rst`=1.
- Reset mid-access: the access is dropped with no `cpu_done`, and `stale_cnt` is cleared.
- Write accepted at cycle N:
  - with `ram_busy`=0: `ram_wr_en` and `cpu_done` at N+1, next accept at N+2;
  - each busy cycle adds one cycle.
- Read accepted at N:
  - `ram_rd_en` at N+1;
  - `ram_rd_ready` seen at cycle M (M ≥ N+2): pop and capture at M, `cpu_done` at M+1, next accept at M+2.
- `ram_addr`/`ram_wr_data` stay stable from accept until the state leaves WR or RD.
- Timeout: with the access accepted at N, the `cpu_err` pulse occurs at N+TIMEOUT_CYCLES. No FIFO strobe is asserted in that cycle.

## Test plan
- Write, no back-pressure: req we=1, addr=24'h000123, data=16'hBEEF at cycle 10 -> `ram_wr_en`=1 with addr 000123 and data BEEF at cycle 11, `cpu_done`=1 at 11, `cpu_ready`=1 at 12.
- Back-pressure: `ram_busy` held high for 5 cycles after a write accept -> no `ram_wr_en` during busy, `ram_wr_en` and `cpu_done` in the first cycle with busy=0, address stable throughout.
- Read: req we=0, addr=24'h0000A0, model returns 16'h1234 with `ram_rd_ready` 6 cycles after `ram_rd_en` -> exactly one `ram_rd_pop`, `cpu_rdata`=1234 with `cpu_done` one cycle later, `cpu_err`=0.
- Read timeout then late data:
  - setup: TIMEOUT_CYCLES=16, model never responds;
  - required: `cpu_done`+`cpu_err` with `cpu_rdata`=FFFF at accept+16, `err_sticky`=1, `stale_cnt`=1;
  - then: late 16'hAAAA arrives while IDLE -> popped and discarded; the next read returns its own data 16'h5555.
- Stale saturation: 7 consecutive read timeouts -> `cpu_ready`=0 until one stale word is drained, then `cpu_ready`=1.
- `err_clr` alone clears `err_sticky`; `err_clr` coincident with a timeout -> `err_sticky`=1. Reset asserted in RD_WAIT -> IDLE, no `cpu_done`, `stale_cnt`=0.
